// File: rtl/pwm_decoder_pkg.sv
// Shared state encoding and default tick constants for the PWM pulse decoder.
// One tick equals 1 us at a 1 MHz sample_clk.
package pwm_decoder_pkg;

  typedef enum logic [1:0] {
    WAIT_LOW,
    WAIT_RISE,
    MEASURE
  } pwm_state_t;

  localparam int DEF_WIDTH_BITS    = 12;
  localparam int DEF_MIN_WIDTH     = 900;
  localparam int DEF_MAX_WIDTH     = 2100;
  localparam int DEF_TIMEOUT_TICKS = 25000;
  localparam int DEF_PERIOD_BITS   = 16;

endpackage

// File: rtl/sat_counter.sv
// Up-counter that sticks at MAX; clear has priority over increment.
module sat_counter #(
  parameter int          N   = 8,
  parameter int unsigned MAX = 255
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         clear,
  input  logic         inc,
  output logic [N-1:0] count,
  output logic         at_max
);

  localparam logic [N-1:0] LP_MAX = N'(MAX);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      count <= '0;
    end else if (clear) begin
      count <= '0;
    end else if (inc && !at_max) begin
      count <= count + 1'b1;
    end
  end

  assign at_max = (count == LP_MAX);

endmodule

// File: rtl/pwm_pulse_decoder.sv
// RC/PWM pulse-width decoder with range check and loss-of-signal flag.
// Define PWM_PERIOD_MEASURE_EN to enable rising-to-rising period measurement.
module pwm_pulse_decoder
  import pwm_decoder_pkg::*;
#(
  parameter int WIDTH_BITS    = DEF_WIDTH_BITS,
  parameter int MIN_WIDTH     = DEF_MIN_WIDTH,
  parameter int MAX_WIDTH     = DEF_MAX_WIDTH,
  parameter int TIMEOUT_TICKS = DEF_TIMEOUT_TICKS,
  parameter int PERIOD_BITS   = DEF_PERIOD_BITS
) (
  input  logic                   sample_clk,
  input  logic                   reset,
  input  logic                   filtered_in,
  output logic [WIDTH_BITS-1:0]  pulse_width,
  output logic                   width_valid,
  output logic                   range_error,
  output logic                   signal_lost,
  output logic [PERIOD_BITS-1:0] period_out
);

  localparam int LC_BITS = $clog2(TIMEOUT_TICKS + 1);
  localparam logic [WIDTH_BITS-1:0] LP_MIN = WIDTH_BITS'(MIN_WIDTH);
  localparam logic [WIDTH_BITS-1:0] LP_MAX = WIDTH_BITS'(MAX_WIDTH);
  localparam logic [LC_BITS-1:0] LP_TO_M1 = LC_BITS'(TIMEOUT_TICKS - 1);

  pwm_state_t            r_state;
  pwm_state_t            w_state_nxt;
  logic [WIDTH_BITS-1:0] r_high_cnt;
  logic [WIDTH_BITS-1:0] w_high_cnt_nxt;
  logic                  r_prev_in;
  logic                  w_rise;
  logic                  w_fall;
  logic                  w_accept;
  logic                  w_reject;
  logic [WIDTH_BITS-1:0] r_pulse_width;
  logic                  r_width_valid;
  logic                  r_range_error;
  logic                  r_signal_lost;
  logic [LC_BITS-1:0]    w_lost_cnt;
  logic                  w_lost_at_max;
  logic                  w_lost_hit;

  assign w_rise = filtered_in & ~r_prev_in;
  assign w_fall = ~filtered_in & r_prev_in;

  always_comb begin
    w_state_nxt    = r_state;
    w_high_cnt_nxt = r_high_cnt;
    w_accept       = 1'b0;
    w_reject       = 1'b0;
    unique case (r_state)
      WAIT_LOW: begin
        if (!filtered_in) w_state_nxt = WAIT_RISE;
      end
      WAIT_RISE: begin
        if (w_rise) begin
          w_state_nxt    = MEASURE;
          w_high_cnt_nxt = WIDTH_BITS'(1);
        end
      end
      MEASURE: begin
        if (filtered_in) begin
          // stuck high: abandon before the counter passes MAX_WIDTH
          if (r_high_cnt == LP_MAX) begin
            w_reject    = 1'b1;
            w_state_nxt = WAIT_LOW;
          end else begin
            w_high_cnt_nxt = r_high_cnt + 1'b1;
          end
        end else if (w_fall) begin
          if (r_high_cnt >= LP_MIN && r_high_cnt <= LP_MAX) begin
            w_accept = 1'b1;
          end else begin
            w_reject = 1'b1;
          end
          w_state_nxt = WAIT_RISE;
        end
      end
      default: w_state_nxt = WAIT_LOW;
    endcase
  end

  always_ff @(posedge sample_clk or posedge reset) begin
    if (reset) begin
      r_state       <= WAIT_LOW;
      r_high_cnt    <= '0;
      r_prev_in     <= 1'b0;
      r_pulse_width <= '0;
      r_width_valid <= 1'b0;
      r_range_error <= 1'b0;
      r_signal_lost <= 1'b1;
    end else begin
      r_state       <= w_state_nxt;
      r_high_cnt    <= w_high_cnt_nxt;
      r_prev_in     <= filtered_in;
      r_width_valid <= w_accept;
      r_range_error <= w_reject;
      if (w_accept) r_pulse_width <= r_high_cnt;
      if (w_accept) begin
        r_signal_lost <= 1'b0;
      end else if (w_lost_hit) begin
        r_signal_lost <= 1'b1;
      end
    end
  end

  sat_counter #(
    .N   (LC_BITS),
    .MAX (TIMEOUT_TICKS)
  ) u_lost_cnt (
    .clk    (sample_clk),
    .reset  (reset),
    .clear  (w_accept),
    .inc    (1'b1),
    .count  (w_lost_cnt),
    .at_max (w_lost_at_max)
  );

  // flag rises on the same edge the counter lands on TIMEOUT_TICKS
  assign w_lost_hit = (w_lost_cnt == LP_TO_M1) & ~w_lost_at_max;

`ifdef PWM_PERIOD_MEASURE_EN
  logic [PERIOD_BITS-1:0] w_per_cnt;
  logic                   w_per_at_max;
  logic                   r_seen_rise;
  logic [PERIOD_BITS-1:0] r_period_out;

  sat_counter #(
    .N   (PERIOD_BITS),
    .MAX (2**PERIOD_BITS - 1)
  ) u_per_cnt (
    .clk    (sample_clk),
    .reset  (reset),
    .clear  (w_rise),
    .inc    (1'b1),
    .count  (w_per_cnt),
    .at_max (w_per_at_max)
  );

  always_ff @(posedge sample_clk or posedge reset) begin
    if (reset) begin
      r_seen_rise  <= 1'b0;
      r_period_out <= '0;
    end else if (w_rise) begin
      r_seen_rise <= 1'b1;
      if (r_seen_rise) begin
        r_period_out <= w_per_at_max ? w_per_cnt : w_per_cnt + 1'b1;
      end
    end
  end

  assign period_out = r_period_out;
`else
  assign period_out = '0;
`endif

  assign pulse_width = r_pulse_width;
  assign width_valid = r_width_valid;
  assign range_error = r_range_error;
  assign signal_lost = r_signal_lost;

endmodule
